seg_scan_capture: RTL and testbench

Receive-side counterpart of the multiplexed 7-segment driver. It samples the scanned cathode bus Cx and anode bus AN, waits for each scan slot to settle, and captures the segment pattern into a per-digit register. It decodes each captured pattern back to a hex nibble. It is used for board-level loopback and self-check of the display path, and as a display monitor in system benches.

---
 rtl/seg_scan_capture.sv | 197 +++++++++++++++++++
 tb/tb_seg_scan_capture.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// seg_scan_capture
//   Receive side of a multiplexed 7-segment display path. It synchronises the
//   scanned cathode bus (Cx) and anode bus (AN) into sysCLK and waits for the
//   combined {AN,Cx} value to settle. It then writes the settled segment
//   pattern into the slot selected by the single low anode line, and decodes
//   that pattern back to a hex nibble.
//
// Ports
//   sysCLK      system clock (only clock)
//   resetN      asynchronous active-low reset
//   Cx[7:0]     cathode bus, active-low; [6:0] = g..a, [7] = DP
//   AN[D-1:0]   anode bus, active-low one-hot
//   clr         synchronous clear of captured flags and frame tracking
//   digit_pat   raw captured Cx per slot, slot i at [8i+7:8i]
//   digit_hex   decoded nibble per slot, slot i at [4i+3:4i]
//   hex_ok      slot pattern (DP ignored) is one of the 16 hex glyphs
//   captured    slot committed since reset/clr
//   frame_done  one-cycle pulse when a new scan frame starts
//   scan_err    one-cycle pulse when a settled AN has more than one low bit
//
// Optional feature macro: SEG_CAPTURE_TIMEOUT_EN
//   When defined, each slot has a staleness counter. A slot that is not
//   refreshed for TIMEOUT cycles drops its captured and hex_ok bits.
//   digit_pat is kept.

module seg_scan_capture #(
    parameter int DIGITS  = 8,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic                  sysCLK,
    input  logic                  resetN,
    input  logic [7:0]            Cx,
    input  logic [DIGITS-1:0]     AN,
    input  logic                  clr,
    output logic [DIGITS*8-1:0]   digit_pat,
    output logic [DIGITS*4-1:0]   digit_hex,
    output logic [DIGITS-1:0]     hex_ok,
    output logic [DIGITS-1:0]     captured,
    output logic                  frame_done,
    output logic                  scan_err
);

    localparam int         IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0] CNT_COMMIT = 8'(SETTLE - 1);
    localparam logic [7:0] CNT_MAX    = 8'(SETTLE);

    logic [7:0]        cx_s1, cx_s2, cx_prev;
    logic [DIGITS-1:0] an_s1, an_s2, an_prev;
    logic [7:0]        cnt;
    logic [DIGITS-1:0] frame_mask;

    logic              same;
    logic              commit;
    logic [DIGITS-1:0] an_sel;
    logic              one_sel;
    logic              multi_sel;
    logic [IW-1:0]     sel_idx;
    logic [4:0]        dec;        // {ok, nibble}
    logic [DIGITS-1:0] expire;

    // Active-low glyph table. The returned value is {match, nibble}.
    function automatic logic [4:0] decode(input logic [6:0] c);
        logic [4:0] r;
        case (c)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // Two-flop synchroniser, previous-sample register and settle counter.
    always_ff @(posedge sysCLK or negedge resetN) begin
        if (!resetN) begin
            cx_s1   <= '0;
            cx_s2   <= '0;
            cx_prev <= '0;
            an_s1   <= '0;
            an_s2   <= '0;
            an_prev <= '0;
            cnt     <= '0;
        end else begin
            cx_s1   <= Cx;
            cx_s2   <= cx_s1;
            cx_prev <= cx_s2;
            an_s1   <= AN;
            an_s2   <= an_s1;
            an_prev <= an_s2;
            if (!same)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 8'd1;
        end
    end

    assign same   = (an_s2 == an_prev) && (cx_s2 == cx_prev);
    // cnt passes SETTLE-1 exactly once per stable run, so a commit fires once
    // per settled value. The counter then parks at SETTLE.
    assign commit = same && (cnt == CNT_COMMIT);

    assign an_sel    = ~an_s2;
    assign multi_sel = (an_sel & (an_sel - DIGITS'(1))) != '0;
    assign one_sel   = (an_sel != '0) && !multi_sel;
    assign dec       = decode(cx_s2[6:0]);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++)
            if (an_sel[i]) sel_idx = IW'(i);
    end

`ifdef SEG_CAPTURE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] stale [DIGITS];

    always_ff @(posedge sysCLK or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DIGITS; i++) stale[i] <= '0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (commit && one_sel && (sel_idx == IW'(i)))
                    stale[i] <= '0;
                else if (stale[i] != TW'(TIMEOUT))
                    stale[i] <= stale[i] + TW'(1);
            end
        end
    end

    // Fires on the edge where the counter reaches TIMEOUT.
    always_comb begin
        for (int i = 0; i < DIGITS; i++)
            expire[i] = (stale[i] == TW'(TIMEOUT - 1));
    end
`else
    assign expire = '0;
`endif

    // Capture registers and frame tracking. Later assignments win, so a commit
    // overrides a clr or expiry on the same edge.
    always_ff @(posedge sysCLK or negedge resetN) begin
        if (!resetN) begin
            digit_pat  <= '1;
            digit_hex  <= '0;
            hex_ok     <= '0;
            captured   <= '0;
            frame_mask <= '0;
            frame_done <= 1'b0;
            scan_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            scan_err   <= 1'b0;
            if (clr) begin
                captured   <= '0;
                frame_mask <= '0;
            end
            for (int i = 0; i < DIGITS; i++) begin
                if (expire[i]) begin
                    captured[i] <= 1'b0;
                    hex_ok[i]   <= 1'b0;
                end
            end
            if (commit) begin
                if (multi_sel) begin
                    scan_err <= 1'b1;
                end else if (one_sel) begin
                    digit_pat[sel_idx*8 +: 8] <= cx_s2;
                    digit_hex[sel_idx*4 +: 4] <= dec[3:0];
                    hex_ok[sel_idx]           <= dec[4];
                    captured[sel_idx]         <= 1'b1;
                    // Revisiting a slot already seen this frame starts a new frame.
                    if (frame_mask[sel_idx]) begin
                        frame_done <= 1'b1;
                        frame_mask <= DIGITS'(1) << sel_idx;
                    end else begin
                        frame_mask[sel_idx] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture
//   Directed bench for seg_scan_capture. It uses a table of glyph vectors
//   plus hand-written sequences for the settle boundary, multi-select, frame
//   wrap, clr and timeout.

module tb_seg_scan_capture;

    localparam int DIGITS  = 8;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;

    logic                 sysCLK = 1'b0;
    logic                 resetN = 1'b0;
    logic [7:0]           Cx     = 8'hFF;
    logic [DIGITS-1:0]    AN     = '1;
    logic                 clr    = 1'b0;
    logic [DIGITS*8-1:0]  digit_pat;
    logic [DIGITS*4-1:0]  digit_hex;
    logic [DIGITS-1:0]    hex_ok;
    logic [DIGITS-1:0]    captured;
    logic                 frame_done;
    logic                 scan_err;

    seg_scan_capture #(
        .DIGITS  (DIGITS),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .sysCLK     (sysCLK),
        .resetN     (resetN),
        .Cx         (Cx),
        .AN         (AN),
        .clr        (clr),
        .digit_pat  (digit_pat),
        .digit_hex  (digit_hex),
        .hex_ok     (hex_ok),
        .captured   (captured),
        .frame_done (frame_done),
        .scan_err   (scan_err)
    );

    // ---------------- clock / reset ----------------
    always #5 sysCLK = ~sysCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- counters / scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    int fd_cnt   = 0;
    int se_cnt   = 0;
    logic [12:0] exp_q[$];   // {pat, hex, ok}

    always @(negedge sysCLK) begin
        if (resetN) begin
            if (frame_done) fd_cnt++;
            if (scan_err)   se_cnt++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge sysCLK);
        #1;
    endtask

    task automatic drive(input logic [7:0] an, input logic [7:0] cx);
        AN = an;
        Cx = cx;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         slot;
        logic [7:0] cx;
        logic [3:0] hex;
        logic       ok;
    } vec_t;

    vec_t vecs[20];

    initial begin
        logic [7:0]  an;
        logic [12:0] got;
        logic [12:0] exp;
        logic [63:0] snap;
        int          fd_before;

        vecs[0]  = '{0, 8'hC0, 4'h0, 1'b1};
        vecs[1]  = '{1, 8'hF9, 4'h1, 1'b1};
        vecs[2]  = '{2, 8'hA4, 4'h2, 1'b1};
        vecs[3]  = '{3, 8'hB0, 4'h3, 1'b1};
        vecs[4]  = '{4, 8'h99, 4'h4, 1'b1};
        vecs[5]  = '{5, 8'h92, 4'h5, 1'b1};
        vecs[6]  = '{6, 8'h82, 4'h6, 1'b1};
        vecs[7]  = '{7, 8'hF8, 4'h7, 1'b1};
        vecs[8]  = '{0, 8'h80, 4'h8, 1'b1};
        vecs[9]  = '{1, 8'h90, 4'h9, 1'b1};
        vecs[10] = '{2, 8'h88, 4'hA, 1'b1};
        vecs[11] = '{3, 8'h83, 4'hB, 1'b1};
        vecs[12] = '{4, 8'hC6, 4'hC, 1'b1};
        vecs[13] = '{5, 8'hA1, 4'hD, 1'b1};
        vecs[14] = '{6, 8'h86, 4'hE, 1'b1};
        vecs[15] = '{7, 8'h8E, 4'hF, 1'b1};
        vecs[16] = '{0, 8'h7F, 4'h0, 1'b0};   // DP lit, segments are not a glyph
        vecs[17] = '{1, 8'h00, 4'h8, 1'b1};   // "8" with DP lit
        vecs[18] = '{2, 8'hFF, 4'h0, 1'b0};   // all segments dark
        vecs[19] = '{3, 8'h0E, 4'hF, 1'b1};   // "F" with DP lit

        // ---- reset with random pins ----
        for (int i = 0; i < 5; i++) begin
            drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            cyc(1);
            chk("reset_pat", 64'(digit_pat), {64{1'b1}});
            chk("reset_cap_ok", {captured, hex_ok}, 64'h0);
            chk("reset_hex", 64'(digit_hex), 64'h0);
            chk("reset_pulses", {frame_done, scan_err}, 64'h0);
        end
        drive(8'hFF, 8'hFF);
        resetN = 1'b1;
        cyc(10);

        // ---- single commit, latency SETTLE+3 ----
        drive(8'hFE, 8'h88);
        cyc(6);
        chk("commit_early", captured, 64'h00);
        cyc(1);
        chk("commit_cap", captured, 64'h01);
        chk("commit_pat", digit_pat[7:0], 64'h88);
        chk("commit_hex", digit_hex[3:0], 64'hA);
        chk("commit_ok", hex_ok[0], 64'h1);
        drive(8'hFF, 8'hFF);
        cyc(8);

        // ---- settle boundary: 3 and 4 cycles rejected, 5 accepted ----
        drive(8'hFD, 8'hC0);
        cyc(3);
        drive(8'hFF, 8'hFF);
        cyc(10);
        chk("glitch3_cap", captured[1], 64'h0);
        chk("glitch3_pat", digit_pat[15:8], 64'hFF);
        drive(8'hFD, 8'hC0);
        cyc(4);
        drive(8'hFF, 8'hFF);
        cyc(10);
        chk("glitch4_cap", captured[1], 64'h0);
        drive(8'hFD, 8'hC0);
        cyc(5);
        drive(8'hFF, 8'hFF);
        cyc(10);
        chk("hold5_cap", captured[1], 64'h1);
        chk("hold5_pat", digit_pat[15:8], 64'hC0);
        chk("hold5_hex_ok", {digit_hex[7:4], hex_ok[1]}, {4'h0, 1'b1});

        // ---- glyph table ----
        for (int v = 0; v < 20; v++) begin
            an = ~(8'd1 << vecs[v].slot);
            drive(an, vecs[v].cx);
            cyc(8);
            exp_q.push_back({vecs[v].cx, vecs[v].hex, vecs[v].ok});
            got = {digit_pat[vecs[v].slot*8 +: 8], digit_hex[vecs[v].slot*4 +: 4], hex_ok[vecs[v].slot]};
            exp = exp_q.pop_front();
            chk($sformatf("vec%0d_pat", v), 64'(got[12:5]), 64'(exp[12:5]));
            chk($sformatf("vec%0d_hex", v), 64'(got[4:1]), 64'(exp[4:1]));
            chk($sformatf("vec%0d_ok", v), 64'(got[0]), 64'(exp[0]));
        end

        // ---- asynchronous reset mid-frame ----
        resetN = 1'b0;
        #1;
        chk("async_rst_pat", 64'(digit_pat), {64{1'b1}});
        chk("async_rst_cap_ok", {captured, hex_ok}, 64'h0);
        chk("async_rst_hex", 64'(digit_hex), 64'h0);
        cyc(2);
        drive(8'hFF, 8'hFF);
        resetN = 1'b1;
        cyc(10);

        // ---- multi-select ----
        drive(8'hFE, 8'h99);
        cyc(8);
        snap   = 64'(digit_pat);
        se_cnt = 0;
        drive(8'hFC, 8'h88);
        cyc(8);
        drive(8'hFF, 8'hFF);
        cyc(8);
        chk("multi_err_pulses", se_cnt, 64'd1);
        chk("multi_pat", 64'(digit_pat), snap);
        chk("multi_cap", captured, 64'h01);

        // ---- frame wrap: 3,0,1,2,3 ----
        pulse_clr();
        chk("clr_cap", captured, 64'h00);
        fd_cnt = 0;
        drive(8'hF7, 8'hB0); cyc(10);
        drive(8'hFE, 8'hB0); cyc(10);
        drive(8'hFD, 8'hB0); cyc(10);
        drive(8'hFB, 8'hB0); cyc(10);
        chk("frame_early", fd_cnt, 64'd0);
        drive(8'hF7, 8'hB0); cyc(10);
        chk("frame_once", fd_cnt, 64'd1);
        chk("frame_hex", digit_hex[15:0], 64'h3333);
        chk("frame_cap", captured, 64'h0F);

        // ---- clr keeps data and restarts frame tracking ----
        drive(8'hFF, 8'hFF);
        cyc(8);
        pulse_clr();
        chk("clr2_cap", captured, 64'h00);
        chk("clr2_keep_hex", digit_hex[15:0], 64'h3333);
        chk("clr2_keep_pat", digit_pat[31:24], 64'hB0);
        fd_before = fd_cnt;
        drive(8'hF7, 8'hB0); cyc(10);
        chk("clr2_no_frame", fd_cnt, 64'(fd_before));
        chk("clr2_cap3", captured, 64'h08);

        // ---- staleness timeout ----
        drive(8'hFF, 8'hFF);
        cyc(8);
        pulse_clr();
        drive(8'hFB, 8'hA4);
        cyc(7);
        chk("to_commit", captured[2], 64'h1);
        drive(8'hFF, 8'hFF);
`ifdef SEG_CAPTURE_TIMEOUT_EN
        cyc(99);
        chk("to_before", captured[2], 64'h1);
        cyc(1);
        chk("to_cap", captured[2], 64'h0);
        chk("to_ok", hex_ok[2], 64'h0);
        chk("to_pat", digit_pat[23:16], 64'hA4);
`else
        cyc(150);
        chk("no_to_cap", captured[2], 64'h1);
        chk("no_to_ok", hex_ok[2], 64'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
